// File: rtl/am_mod_pkg.sv
// rtl/am_mod_pkg.sv - shared types and helpers for the AM/ASK modulator pipe
package am_mod_pkg;

  typedef enum logic [1:0] {
    MODE_AM  = 2'd0,
    MODE_DSB = 2'd1,
    MODE_ASK = 2'd2,
    MODE_BYP = 2'd3
  } mode_e;

  // One bit of headroom over the wider of sext(mod) and zext(depth).
  function automatic int sum_width(input int mod_w, input int depth_w);
    return ((mod_w > depth_w + 1) ? mod_w : depth_w + 1) + 1;
  endfunction

  // Two's complement to offset-binary: invert the sign bit of a w-bit sample.
  function automatic logic [31:0] offset_binary(input logic [31:0] s, input int w);
    return s ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/am_sat.sv
// rtl/am_sat.sv - arithmetic right shift, saturate to OUT_W, flag the clamp
module am_sat #(
  parameter int IN_W  = 25,
  parameter int SHIFT = 8,
  parameter int OUT_W = 14
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             clamp
);

  localparam int EXT_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] sh;
  logic hi;
  logic lo;

  assign ext   = EXT_W'($signed(din));
  assign sh    = ext >>> SHIFT;
  assign hi    = sh > MAX_V;
  assign lo    = sh < MIN_V;
  assign clamp = hi | lo;
  assign dout  = hi ? MAX_V[OUT_W-1:0] : (lo ? MIN_V[OUT_W-1:0] : sh[OUT_W-1:0]);

endmodule

// File: rtl/am_mod_pipe.sv
// rtl/am_mod_pipe.sv - 3-stage AM/DSB/ASK/bypass modulator with saturation and DAC offset output
module am_mod_pipe
  import am_mod_pkg::*;
#(
  parameter int MOD_W   = 8,
  parameter int CAR_W   = 14,
  parameter int DEPTH_W = 9,
  parameter int OUT_W   = 14,
  parameter int SHIFT   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [MOD_W-1:0]   mod_in,
  input  logic [CAR_W-1:0]   carrier_in,
  input  logic               key_in,
  input  logic [1:0]         mode,
  input  logic               depth_wr,
  input  logic [DEPTH_W-1:0] depth_in,
  input  logic               sat_clr,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_s,
  output logic [OUT_W-1:0]   out_u,
  output logic               sat_flag
);

  localparam int SUM_W  = sum_width(MOD_W, DEPTH_W);
  localparam int PROD_W = SUM_W + CAR_W;

  logic [DEPTH_W-1:0]       depth_q;
  mode_e                    mode_sel;
  logic signed [SUM_W-1:0]  mod_ext;
  logic signed [SUM_W-1:0]  dep_ext;
  logic signed [SUM_W-1:0]  sum_d;

  logic                     s1_valid;
  mode_e                    s1_mode;
  logic signed [SUM_W-1:0]  s1_sum;
  logic signed [CAR_W-1:0]  s1_car;

  logic                     s2_valid;
  mode_e                    s2_mode;
  logic signed [PROD_W-1:0] s2_prod;
  logic signed [CAR_W-1:0]  s2_car;

  logic [OUT_W-1:0]         mul_out;
  logic [OUT_W-1:0]         byp_out;
  logic                     mul_clamp;
  logic                     byp_clamp;
  logic [OUT_W-1:0]         res;
  logic                     res_clamp;

  assign mode_sel = mode_e'(mode);
  assign mod_ext  = SUM_W'($signed(mod_in));
  assign dep_ext  = $signed(SUM_W'(depth_q));

  always_comb begin
    sum_d = '0;
    case (mode_sel)
      MODE_AM:  sum_d = mod_ext + dep_ext;
      MODE_DSB: sum_d = mod_ext;
      MODE_ASK: sum_d = key_in ? dep_ext : '0;
      default:  sum_d = '0;
    endcase
  end

  am_sat #(.IN_W(PROD_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_sat_mul (
    .din   (s2_prod),
    .dout  (mul_out),
    .clamp (mul_clamp)
  );

  // Bypass reuses the saturator with no shift so a wide carrier still clamps cleanly.
  am_sat #(.IN_W(CAR_W), .SHIFT(0), .OUT_W(OUT_W)) u_sat_byp (
    .din   (s2_car),
    .dout  (byp_out),
    .clamp (byp_clamp)
  );

  assign res       = (s2_mode == MODE_BYP) ? byp_out : mul_out;
  assign res_clamp = (s2_mode == MODE_BYP) ? byp_clamp : mul_clamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q   <= '0;
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_AM;
      s1_sum    <= '0;
      s1_car    <= '0;
      s2_valid  <= 1'b0;
      s2_mode   <= MODE_AM;
      s2_prod   <= '0;
      s2_car    <= '0;
      out_valid <= 1'b0;
      out_s     <= '0;
      out_u     <= {1'b1, {(OUT_W-1){1'b0}}};
      sat_flag  <= 1'b0;
    end else begin
      // Stage 1 reads depth_q before this cycle's write lands, so a coincident sample sees the old depth.
      if (depth_wr) depth_q <= depth_in;

      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= mode_sel;
        s1_sum  <= sum_d;
        s1_car  <= $signed(carrier_in);
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode <= s1_mode;
        s2_prod <= PROD_W'(s1_sum) * PROD_W'(s1_car);
        s2_car  <= s1_car;
      end

      out_valid <= s2_valid;
      if (s2_valid) begin
        out_s <= res;
        out_u <= OUT_W'(offset_binary(32'(res), OUT_W));
      end

      if (s2_valid && res_clamp) sat_flag <= 1'b1;
      else if (sat_clr)          sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_am_mod_pipe.sv
// tb/tb_am_mod_pipe.sv - randomized and directed checks of am_mod_pipe against a sample-level model
module tb_am_mod_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  mod_in = '0;
  logic [13:0] carrier_in = '0;
  logic        key_in = 1'b0;
  logic [1:0]  mode = '0;
  logic        depth_wr = 1'b0;
  logic [8:0]  depth_in = '0;
  logic        sat_clr = 1'b0;
  logic        out_valid;
  logic [13:0] out_s;
  logic [13:0] out_u;
  logic        sat_flag;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit v;
    int val;
    bit clamp;
  } ent_t;

  ent_t h0, h1, h2;
  int   m_depth;
  int   exp_s;
  bit   exp_v;
  bit   exp_sat;

  am_mod_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .mod_in     (mod_in),
    .carrier_in (carrier_in),
    .key_in     (key_in),
    .mode       (mode),
    .depth_wr   (depth_wr),
    .depth_in   (depth_in),
    .sat_clr    (sat_clr),
    .out_valid  (out_valid),
    .out_s      (out_s),
    .out_u      (out_u),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Envelope times carrier, divided by 256 with floor, clamped to 14-bit signed.
  function automatic ent_t ref_sample(input bit v, input int m, input int c, input bit k,
                                      input int md, input int dep);
    ent_t   e;
    longint r;
    int     sum;
    case (md)
      0:       sum = m + dep;
      1:       sum = m;
      2:       sum = k ? dep : 0;
      default: sum = 0;
    endcase
    if (md == 3) r = c;
    else         r = (longint'(sum) * c) >>> 8;
    e.v     = v;
    e.clamp = (r > 8191) || (r < -8192);
    e.val   = (r > 8191) ? 8191 : ((r < -8192) ? -8192 : int'(r));
    return e;
  endfunction

  task automatic reset_model();
    h0 = '{0, 0, 0};
    h1 = '{0, 0, 0};
    h2 = '{0, 0, 0};
    m_depth = 0;
    exp_s   = 0;
    exp_v   = 0;
    exp_sat = 0;
  endtask

  task automatic step(input bit v, input int m, input int c, input bit k, input int md,
                      input bit dwr = 0, input int din = 0, input bit clr = 0);
    ent_t e;
    @(negedge clk);
    in_valid   = v;
    mod_in     = 8'(m);
    carrier_in = 14'(c);
    key_in     = k;
    mode       = 2'(md);
    depth_wr   = dwr;
    depth_in   = 9'(din);
    sat_clr    = clr;
    e = ref_sample(v, m, c, k, md, m_depth);
    if (dwr) m_depth = din;
    @(posedge clk);
    #1;
    h2 = h1;
    h1 = h0;
    h0 = e;
    exp_v = h2.v;
    if (h2.v) exp_s = h2.val;
    if (h2.v && h2.clamp) exp_sat = 1;
    else if (clr)         exp_sat = 0;
    check("out_valid", longint'(out_valid), longint'(exp_v));
    check("out_s", longint'($signed(out_s)), longint'(exp_s));
    check("out_u", longint'(out_u), longint'(exp_s + 8192));
    check("sat_flag", longint'(sat_flag), longint'(exp_sat));
  endtask

  task automatic flush(input int n = 3);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic rand_step();
    bit v, dwr, clr, k;
    int m, c, md, din;
    v   = ($urandom_range(0, 3) != 0);
    m   = int'($urandom_range(0, 255)) - 128;
    c   = int'($urandom_range(0, 16383)) - 8192;
    k   = 1'($urandom_range(0, 1));
    md  = int'($urandom_range(0, 3));
    dwr = ($urandom_range(0, 9) == 0);
    din = int'($urandom_range(0, 511));
    clr = ($urandom_range(0, 19) == 0);
    step(v, m, c, k, md, dwr, din, clr);
  endtask

  initial begin
    reset_model();
    #12;
    check("rst_valid", longint'(out_valid), 0);
    check("rst_out_s", longint'(out_s), 0);
    check("rst_out_u", longint'(out_u), 8192);
    check("rst_sat", longint'(sat_flag), 0);
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 0, 0, 0, 0, 1, 170);
    step(1, 0, 8191, 0, 0);
    flush();
    check("am170_s", longint'($signed(out_s)), 5439);
    check("am170_u", longint'(out_u), 13631);
    check("am170_sat", longint'(sat_flag), 0);

    step(0, 0, 0, 0, 0, 1, 511);
    step(1, 127, 8191, 0, 0);
    flush();
    check("clamp_hi_s", longint'($signed(out_s)), 8191);
    check("clamp_hi_u", longint'(out_u), 16383);
    step(1, 127, -8192, 0, 0);
    flush();
    check("clamp_lo_s", longint'($signed(out_s)), -8192);
    check("clamp_lo_u", longint'(out_u), 0);
    check("clamp_sat", longint'(sat_flag), 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("sat_clr", longint'(sat_flag), 0);
    step(1, 127, 8191, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("sat_set_wins", longint'(sat_flag), 1);

    step(1, -128, 100, 0, 1);
    flush();
    check("dsb_s", longint'($signed(out_s)), -50);
    check("dsb_u", longint'(out_u), 8142);

    step(1, 50, 1000, 0, 2);
    flush();
    check("ask0_s", longint'($signed(out_s)), 0);
    check("ask0_u", longint'(out_u), 8192);
    step(0, 0, 0, 0, 0, 1, 256);
    step(1, 0, -300, 1, 2);
    flush();
    check("ask1_s", longint'($signed(out_s)), -300);

    step(0, 0, 0, 0, 0, 1, 100);
    step(1, 0, 8191, 0, 0, 1, 200);
    step(1, 0, 8191, 0, 0);
    step(0, 0, 0, 0, 0);
    check("depth_old", longint'($signed(out_s)), 3199);
    step(0, 0, 0, 0, 0);
    check("depth_new", longint'($signed(out_s)), 6399);

    step(1, 0, -5, 0, 3);
    flush();
    check("bypass_s", longint'($signed(out_s)), -5);

    step(1, 10, 500, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, -20, 700, 0, 1);
    step(1, 30, -900, 0, 1);
    flush(4);

    repeat (600) rand_step();

    repeat (3) step(1, 127, 8191, 0, 0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    depth_wr = 1'b0;
    sat_clr  = 1'b0;
    #1;
    check("midrst_valid", longint'(out_valid), 0);
    check("midrst_out_u", longint'(out_u), 8192);
    check("midrst_sat", longint'(sat_flag), 0);
    reset_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush(4);
    repeat (40) rand_step();
    flush();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/am_mod_pipe.md
Name: am_mod_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width AM/ASK modulator datapath.
- Multiplies a signed carrier sample by a mode-dependent envelope: AM (depth+m), DSB-SC (m), ASK (keyed depth) or carrier bypass.
- Applies an arithmetic shift, saturates, and outputs both two's-complement and offset-binary (DAC-ready) samples.
- Sits between the carrier NCO/FSK source and the DAC interface; a valid strobe tracks samples through the pipe.

Parameters:
- MOD_W, 8: modulating-signal width, signed.
- CAR_W, 14: carrier width, signed.
- DEPTH_W, 9: depth/offset width, unsigned.
- OUT_W, 14: output width.
- SHIFT, 8: arithmetic right shift applied to the product before saturation.

Ports:
- clk  in  1  sample clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  mod_in/carrier_in/key_in valid this cycle.
- mod_in  in  MOD_W  signed modulating sample.
- carrier_in  in  CAR_W  signed carrier sample.
- key_in  in  1  ASK key bit.
- mode  in  2  0=AM, 1=DSB-SC, 2=ASK, 3=carrier bypass.
- depth_wr  in  1  load depth_in into the depth register.
- depth_in  in  DEPTH_W  new depth value.
- sat_clr  in  1  clear the sticky saturation flag.
- out_valid  out  1  out_s/out_u valid.
- out_s  out  OUT_W  signed modulated sample.
- out_u  out  OUT_W  offset-binary sample for the DAC.
- sat_flag  out  1  sticky: saturation occurred.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - out_valid=0, out_s=0, out_u=2^(OUT_W-1) (DAC midscale), sat_flag=0.
  - Depth register=0; all pipe registers cleared.
  - Reset mid-stream discards all in-flight samples; no out_valid until new in_valid after release.
- Depth register:
  - Loads on depth_wr.
  - A sample accepted in the same cycle as depth_wr uses the OLD depth; the new depth applies from the next accepted sample.
- Stage 1 (register on in_valid): latch mode, depth, key and carrier; compute the envelope sum in SUM_W = max(MOD_W, DEPTH_W+1)+1 bits signed.
  - AM: sum = sext(mod_in) + zext(depth).
  - DSB-SC: sum = sext(mod_in).
  - ASK: sum = key_in ? zext(depth) : 0.
  - Bypass: sum is unused.
- Stage 2: prod = sum * carrier, full width SUM_W+CAR_W signed, no truncation.
- Stage 3:
  - sh = prod >>> SHIFT (arithmetic, floor toward -inf).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Bypass: out_s = carrier_in sign-extended or saturated to OUT_W; shift is not applied.
  - out_u = out_s with MSB inverted (pure offset-binary, no -1 correction).
- Saturation flag:
  - sat_flag sets in the cycle a stage-3 clamp occurs on a valid sample.
  - Simultaneous sat_clr and new saturation: set wins.
- Latency and timing:
  - Fixed 3 cycles from in_valid to out_valid.
  - Full throughput: one sample per clock. No backpressure.
- Bubbles: in_valid=0 propagates as out_valid=0; out_s/out_u hold their last value during bubbles.
- Mode/config changes: mode is sampled per accepted sample, so every output sample is computed with a coherent mode/depth/key set. In-flight samples are unaffected by later changes.

Decomposition:
- Package am_mod_pkg:
  - mode encodings MODE_AM, MODE_DSB, MODE_ASK, MODE_BYP;
  - function computing SUM_W from MOD_W/DEPTH_W;
  - offset-binary conversion function.
- Sub-module am_sat: parametrised arithmetic shift + saturate + clamp-detect, combinational, used in stage 3. It is also reusable by the FSK/PSK output stages.

Test Plan (defaults, SHIFT=8):
- AM, depth_wr 170, mod=0, carrier=8191 -> 3 cycles later out_s=5439, out_u=13631, sat_flag=0.
- AM, depth=511, mod=127, carrier=8191 then carrier=-8192 -> out_s=8191 then -8192, out_u=16383 then 0, sat_flag=1. sat_clr pulse alone -> sat_flag=0; sat_clr coincident with another clamp -> remains 1.
- DSB, mod=-128, carrier=100 -> out_s=-50, out_u=8142. ASK: key=0 -> out_s=0, out_u=8192; key=1, depth=256, carrier=-300 -> out_s=-300.
- Continuous stream with depth_wr 100->200 on cycle N: sample accepted at N uses 100, N+1 uses 200. Bypass carrier=-5 -> out_s=-5.
- in_valid pattern 1,0,1,1 -> out_valid 1,0,1,1 delayed exactly 3 cycles, outputs held in the bubble. Assert rst_n mid-stream -> out_valid=0, out_u=8192, with no stale samples emitted after release.
